tft_spi_tx: RTL and testbench

Byte-level serializer between the scene/init pixel generators and the TFT's SPI pins. It accepts one byte plus its D/C flag per transmit pulse and shifts the byte out MSB-first in SPI mode 0, with chip-select framing per byte. It drives the tft_busy input of upstream producers, which issue a one-cycle transmit pulse only while busy is low.

---
 rtl/tft_spi_tx_pkg.sv | 17 +
 rtl/tft_spi_tick.sv | 31 +++
 rtl/tft_spi_tx.sv | 117 +++++++++++
 tb/tb_tft_spi_tx.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/tft_spi_tx_pkg.sv
// Shared definitions for the TFT SPI path: FSM encodings, D/C levels, default divider.
package tft_spi_tx_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } spi_state_t;

    localparam logic TFT_DC_CMD  = 1'b0;
    localparam logic TFT_DC_DATA = 1'b1;

    localparam int unsigned TFT_SPI_DIV = 2;

endpackage

// File: rtl/tft_spi_tick.sv
// Half-period pulse generator: one-cycle half_tick every CLK_DIV enabled cycles.
// Latency: first pulse CLK_DIV cycles after enable; no backpressure, clr restarts the count.
module tft_spi_tick
    import tft_spi_tx_pkg::*;
#(
    parameter int unsigned CLK_DIV = TFT_SPI_DIV
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    output logic half_tick
);

    localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

    logic [7:0] cnt;

    // Held at RELOAD while disabled so every enable window starts a full period.
    always_ff @(posedge clk) begin
        if (clr || !en) begin
            cnt <= RELOAD;
        end else if (cnt == 8'd0) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - 8'd1;
        end
    end

    assign half_tick = en && (cnt == 8'd0);

endmodule

// File: rtl/tft_spi_tx.sv
// SPI mode-0 byte serializer with per-byte chip select; busy high 18*CLK_DIV+1 cycles per byte.
// Transmit pulses arriving while busy are dropped; upstream must wait for busy low.
module tft_spi_tx
    import tft_spi_tx_pkg::*;
#(
    parameter int unsigned CLK_DIV = TFT_SPI_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       dc,
    input  logic       transmit,
    output logic       busy,
    output logic       tft_sck,
    output logic       tft_mosi,
    output logic       tft_cs,
    output logic       tft_dc
);

    spi_state_t state_q, state_d;
    logic [7:0] shreg_q, shreg_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       sck_d, mosi_d, dc_d, cs_d, busy_d;
    logic       tick_en, half_tick;

    assign tick_en = (state_q == SETUP) || (state_q == SHIFT) || (state_q == HOLD);

    tft_spi_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk       (clk),
        .clr       (rst),
        .en        (tick_en),
        .half_tick (half_tick)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        sck_d     = tft_sck;
        mosi_d    = tft_mosi;
        dc_d      = tft_dc;
        case (state_q)
            IDLE: begin
                if (transmit) begin
                    state_d   = SETUP;
                    shreg_d   = data;
                    dc_d      = dc;
                    mosi_d    = data[7];
                    bit_cnt_d = 3'd0;
                end
            end
            SETUP: begin
                if (half_tick) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (half_tick) begin
                    if (!tft_sck) begin
                        sck_d     = 1'b1;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end else begin
                        sck_d = 1'b0;
                        // bit_cnt wraps to zero after the 8th rise, marking the last fall.
                        if (bit_cnt_q == 3'd0) begin
                            state_d = HOLD;
                        end else begin
                            shreg_d = shreg_q << 1;
                            mosi_d  = shreg_q[6];
                        end
                    end
                end
            end
            HOLD: begin
                if (half_tick) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                mosi_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                sck_d   = 1'b0;
                mosi_d  = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
        cs_d   = !((state_d == SETUP) || (state_d == SHIFT) || (state_d == HOLD));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shreg_q   <= 8'd0;
            bit_cnt_q <= 3'd0;
            busy      <= 1'b0;
            tft_sck   <= 1'b0;
            tft_mosi  <= 1'b0;
            tft_cs    <= 1'b1;
            tft_dc    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            busy      <= busy_d;
            tft_sck   <= sck_d;
            tft_mosi  <= mosi_d;
            tft_cs    <= cs_d;
            tft_dc    <= dc_d;
        end
    end

endmodule

// File: tb/tb_tft_spi_tx.sv
// Drives a CLK_DIV=2 and a CLK_DIV=1 instance from shared stimulus and checks both
// against a cycle-count reference model plus a frame decoder.
module tb_tft_spi_tx;

    logic       clk;
    logic       rst;
    logic [7:0] data;
    logic       dc;
    logic       transmit;

    logic busy_w [2];
    logic sck_w  [2];
    logic mosi_w [2];
    logic cs_w   [2];
    logic dc_w   [2];

    int n_chk  = 0;
    int n_pass = 0;

    tft_spi_tx #(.CLK_DIV(2)) dut0 (
        .clk      (clk),
        .rst      (rst),
        .data     (data),
        .dc       (dc),
        .transmit (transmit),
        .busy     (busy_w[0]),
        .tft_sck  (sck_w[0]),
        .tft_mosi (mosi_w[0]),
        .tft_cs   (cs_w[0]),
        .tft_dc   (dc_w[0])
    );

    tft_spi_tx #(.CLK_DIV(1)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .data     (data),
        .dc       (dc),
        .transmit (transmit),
        .busy     (busy_w[1]),
        .tft_sck  (sck_w[1]),
        .tft_mosi (mosi_w[1]),
        .tft_cs   (cs_w[1]),
        .tft_dc   (dc_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: remaining busy cycles per instance, counted down from 18*D+1.
    int         m_rem  [2] = '{0, 0};
    logic [7:0] m_byte [2] = '{8'd0, 8'd0};
    logic       m_dc   [2] = '{1'b0, 1'b0};

    // Frame decoder state.
    logic       cs_p    [2] = '{1'b1, 1'b1};
    logic       sck_p   [2] = '{1'b0, 1'b0};
    int         rises   [2] = '{0, 0};
    int         low_cnt [2] = '{0, 0};
    logic [7:0] dec     [2] = '{8'd0, 8'd0};
    logic       aborted [2] = '{1'b0, 1'b0};

    int md, me, mh;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            md = (k == 0) ? 2 : 1;
            me = 18 * md + 2 - m_rem[k];

            check($sformatf("d%0d_busy", k), busy_w[k], m_rem[k] != 0);
            check($sformatf("d%0d_dc", k), dc_w[k], m_dc[k]);
            if (m_rem[k] == 0) begin
                check($sformatf("d%0d_idle_cs", k), cs_w[k], 1'b1);
                check($sformatf("d%0d_idle_sck", k), sck_w[k], 1'b0);
                check($sformatf("d%0d_idle_mosi", k), mosi_w[k], 1'b0);
            end else begin
                check($sformatf("d%0d_cs", k), cs_w[k], m_rem[k] == 1);
                if (me <= md) begin
                    check($sformatf("d%0d_setup_sck", k), sck_w[k], 1'b0);
                    check($sformatf("d%0d_setup_mosi", k), mosi_w[k], m_byte[k][7]);
                end else if (me <= 17 * md) begin
                    mh = (me - md - 1) / md;
                    check($sformatf("d%0d_shift_sck", k), sck_w[k], mh % 2);
                    check($sformatf("d%0d_shift_mosi", k), mosi_w[k], m_byte[k][7 - mh / 2]);
                end else begin
                    check($sformatf("d%0d_tail_sck", k), sck_w[k], 1'b0);
                end
            end

            if (cs_p[k] && !cs_w[k]) begin
                rises[k]   = 0;
                low_cnt[k] = 0;
                dec[k]     = 8'd0;
                aborted[k] = 1'b0;
            end
            if (!cs_w[k]) low_cnt[k]++;
            if (sck_w[k] && !sck_p[k]) begin
                rises[k]++;
                dec[k] = {dec[k][6:0], mosi_w[k]};
            end
            if (!cs_p[k] && cs_w[k] && !aborted[k]) begin
                check($sformatf("d%0d_frame_rises", k), rises[k], 8);
                check($sformatf("d%0d_frame_byte", k), dec[k], m_byte[k]);
                check($sformatf("d%0d_frame_cs_low", k), low_cnt[k], 18 * md);
            end
            cs_p[k]  = cs_w[k];
            sck_p[k] = sck_w[k];

            // Advance the model with the inputs the next rising edge will sample.
            if (rst) begin
                if (!cs_w[k]) aborted[k] = 1'b1;
                m_rem[k] = 0;
                m_dc[k]  = 1'b0;
            end else if (m_rem[k] > 0) begin
                m_rem[k]--;
            end else if (transmit) begin
                m_rem[k]  = 18 * md + 1;
                m_byte[k] = data;
                m_dc[k]   = dc;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy_w[0] || busy_w[1]) && n < 300) begin
            step(1);
            n++;
        end
        if (n >= 300) check("idle_timeout", 1, 0);
    endtask

    task automatic pulse(input logic [7:0] b, input logic d);
        transmit = 1'b1;
        data     = b;
        dc       = d;
        step(1);
        transmit = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input logic d);
        wait_idle();
        pulse(b, d);
    endtask

    initial begin
        int   r;
        int   n;
        logic prev;

        rst      = 1'b1;
        transmit = 1'b0;
        data     = 8'd0;
        dc       = 1'b0;
        @(posedge clk);
        #1;
        step(1);
        pulse(8'h55, 1'b1);
        rst = 1'b0;
        step(3);

        send(8'hA5, 1'b1);

        send(8'h3A, 1'b0);
        step(9);
        pulse(8'hFF, 1'b1);

        send(8'h3A, 1'b1);
        send(8'h7B, 1'b1);
        send(8'hD5, 1'b0);

        send(8'h2C, 1'b0);
        send(8'h00, 1'b1);

        send(8'hD5, 1'b1);
        r    = 0;
        n    = 0;
        prev = sck_w[0];
        while (r < 3 && n < 200) begin
            step(1);
            if (sck_w[0] && !prev) r++;
            prev = sck_w[0];
            n++;
        end
        if (n >= 200) check("rise_timeout", 1, 0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(2);
        send(8'h81, 1'b0);

        for (int i = 0; i < 20; i++) begin
            send(8'($urandom), 1'($urandom));
            if ($urandom_range(1, 0) == 1) begin
                step($urandom_range(15, 1));
                pulse(8'($urandom), 1'($urandom));
            end
        end

        wait_idle();
        step(3);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
